// File: rtl/matmul_seq_pkg.sv
// Shared types and sizing helpers for the matrix-multiply sequencer.
package matmul_seq_pkg;

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        FLUSH   = 3'd1,
        COLLECT = 3'd2,
        DRAIN   = 3'd3,
        CLEAR   = 3'd4
    } state_e;

    // Bits needed to hold every value from 0 up to and including max_count.
    function automatic int count_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/seq_result_buf.sv
// Result register file: one synchronous write port, one asynchronous read port.
module seq_result_buf #(
    parameter int width_p     = 8,
    parameter int depth_p     = 4,
    parameter int idx_width_p = 2
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [idx_width_p-1:0] w_idx_i,
    input  logic [width_p-1:0]     w_data_i,
    input  logic [idx_width_p-1:0] r_idx_i,
    output logic [width_p-1:0]     r_data_o
);

    logic [width_p-1:0] mem_q [depth_p];

    // NOTE: no reset on the storage; the sequencer's pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[w_idx_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_idx_i];

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one matrix multiply through the systolic array: load, flush, collect, drain.
// Optional watchdog on result collection is enabled by defining MATMUL_SEQ_TIMEOUT_EN.
module matmul_sequencer
    import matmul_seq_pkg::*;
#(
    parameter int width_p         = 8,
    parameter int array_width_p   = 2,
    parameter int array_height_p  = 2,
    parameter int timeout_width_p = 24
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    input  logic               abort_i,
    output logic               arr_valid_o,
    output logic [width_p-1:0] arr_data_o,
    input  logic               arr_ready_i,
    output logic               arr_flush_o,
    input  logic               arr_valid_i,
    input  logic [width_p-1:0] arr_data_i,
    output logic               arr_yumi_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               done_o,
    output logic               error_o,
    output logic [2:0]         state_o
);

    localparam int num_macs_p = array_width_p * array_height_p;
    localparam int num_ops_p  = 2 * num_macs_p;
    localparam int cnt_w      = count_width(num_ops_p);
    localparam int idx_w      = (num_macs_p > 1) ? $clog2(num_macs_p) : 1;

    localparam logic [cnt_w-1:0] cnt_one   = cnt_w'(1);
    localparam logic [cnt_w-1:0] ops_last  = cnt_w'(num_ops_p - 1);
    localparam logic [cnt_w-1:0] macs_last = cnt_w'(num_macs_p - 1);

    state_e             state_q, state_d;
    logic [cnt_w-1:0]   op_cnt_q, op_cnt_d;
    logic [cnt_w-1:0]   res_cnt_q, res_cnt_d;
    logic [cnt_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic               done_q, done_d;
    logic               buf_we;
    logic [width_p-1:0] buf_rdata;

`ifdef MATMUL_SEQ_TIMEOUT_EN
    logic [timeout_width_p-1:0] wd_q, wd_d;

    // Restart on COLLECT entry (from FLUSH) and on every accepted result.
    assign wd_d = (state_q == FLUSH || (state_q == COLLECT && arr_valid_i)) ? '0 :
                  (state_q == COLLECT) ? wd_q + timeout_width_p'(1) : wd_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    localparam int unused_timeout_width = timeout_width_p;
`endif

    seq_result_buf #(
        .width_p    (width_p),
        .depth_p    (num_macs_p),
        .idx_width_p(idx_w)
    ) u_buf (
        .clk_i   (clk_i),
        .we_i    (buf_we),
        .w_idx_i (res_cnt_q[idx_w-1:0]),
        .w_data_i(arr_data_i),
        .r_idx_i (rd_ptr_q[idx_w-1:0]),
        .r_data_o(buf_rdata)
    );

    // NOTE: every output and next-state value gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        op_cnt_d    = op_cnt_q;
        res_cnt_d   = res_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        done_d      = 1'b0;
        buf_we      = 1'b0;
        ready_o     = 1'b0;
        arr_valid_o = 1'b0;
        arr_data_o  = '0;
        arr_flush_o = 1'b0;
        arr_yumi_o  = 1'b0;
        valid_o     = 1'b0;
        error_o     = 1'b0;

        case (state_q)
            LOAD: begin
                ready_o     = arr_ready_i;
                arr_valid_o = valid_i;
                arr_data_o  = data_i;
                if (valid_i && arr_ready_i) begin
                    if (op_cnt_q == ops_last) begin
                        op_cnt_d = '0;
                        state_d  = FLUSH;
                    end else begin
                        op_cnt_d = op_cnt_q + cnt_one;
                    end
                end
            end
            FLUSH: begin
                arr_flush_o = 1'b1;
                state_d     = COLLECT;
            end
            COLLECT: begin
                arr_yumi_o = arr_valid_i;
                if (arr_valid_i) begin
                    buf_we    = 1'b1;
                    res_cnt_d = res_cnt_q + cnt_one;
                    if (res_cnt_q == macs_last) begin
                        state_d = DRAIN;
                    end
                end
`ifdef MATMUL_SEQ_TIMEOUT_EN
                else if (wd_q == '1) begin
                    error_o = 1'b1;
                    state_d = CLEAR;
                end
`endif
            end
            DRAIN: begin
                valid_o = 1'b1;
                if (yumi_i) begin
                    if (rd_ptr_q == macs_last) begin
                        done_d    = 1'b1;
                        rd_ptr_d  = '0;
                        res_cnt_d = '0;
                        state_d   = LOAD;
                    end else begin
                        rd_ptr_d = rd_ptr_q + cnt_one;
                    end
                end
            end
            CLEAR: begin
                // Flush the array and swallow whatever stale result it is still presenting.
                arr_flush_o = 1'b1;
                arr_yumi_o  = arr_valid_i;
                op_cnt_d    = '0;
                res_cnt_d   = '0;
                rd_ptr_d    = '0;
                state_d     = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        if (abort_i) begin
            state_d = CLEAR;
            done_d  = 1'b0;
            error_o = 1'b0;
        end
    end

    assign data_o  = valid_o ? buf_rdata : '0;
    assign done_o  = done_q;
    assign state_o = state_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= LOAD;
            op_cnt_q  <= '0;
            res_cnt_q <= '0;
            rd_ptr_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_cnt_q  <= op_cnt_d;
            res_cnt_q <= res_cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Controller that sequences one matrix multiply through `systolic_array`. It sits between the operand stream (SIPO output) and the array, and between the array's result port and the display FIFO. It gates operand entry, issues the flush after the last operand, and collects exactly `num_macs_p` results into a local buffer. It then releases those results downstream one at a time before accepting the next job.

## Interface
- `width_p`, 8, element width in bits
- `array_width_p`, 2, array columns
- `array_height_p`, 2, array rows
- `timeout_width_p`, 24, watchdog counter width (used only with `MATMUL_SEQ_TIMEOUT_EN`)
- `clk_i` in 1: single clock
- `reset_i` in 1: asynchronous, active-high reset
- `valid_i` in 1: operand valid
- `data_i` in `width_p`: operand
- `ready_o` out 1: operand accepted when `valid_i & ready_o`
- `abort_i` in 1: synchronous job abort
- `arr_valid_o` out 1 / `arr_data_o` out `width_p`: operand to array
- `arr_ready_i` in 1: array `ready_o`
- `arr_flush_o` out 1: array `flush_i`
- `arr_valid_i` in 1 / `arr_data_i` in `width_p`: array result
- `arr_yumi_o` out 1: array `yumi_i`
- `valid_o` out 1 / `data_o` out `width_p`: result to downstream
- `yumi_i` in 1: downstream consumes `data_o`
- `done_o` out 1: one-cycle pulse on the final downstream consume
- `error_o` out 1: one-cycle pulse on watchdog expiry
- `state_o` out 3: current state encoding (debug LEDs)

## Operation
- Derived constants: `num_macs_p = array_width_p*array_height_p`; `num_ops_p = 2*num_macs_p`.
- States: LOAD (reset state), FLUSH, COLLECT, DRAIN, CLEAR.
- **LOAD**
  - `arr_valid_o = valid_i`; `arr_data_o = data_i`; `ready_o = arr_ready_i`. All are combinational pass-through.
  - `op_cnt` increments per transfer.
  - The transfer that makes `op_cnt == num_ops_p` moves the block to FLUSH and clears `op_cnt`.
- **FLUSH**
  - `arr_flush_o = 1` for exactly one cycle, then COLLECT.
- **COLLECT**
  - `arr_yumi_o = arr_valid_i`.
  - Each handshake writes `arr_data_i` to `buf[res_cnt]` and increments `res_cnt`.
  - Reaching `res_cnt == num_macs_p` moves the block to DRAIN. `arr_yumi_o` is 0 from then on.
- **DRAIN**
  - `valid_o = 1`; `data_o = buf[rd_ptr]`.
  - `yumi_i` increments `rd_ptr`.
  - The yumi at `rd_ptr == num_macs_p-1` pulses `done_o`, clears `res_cnt`/`rd_ptr`, and returns to LOAD.
  - `yumi_i` while `valid_o = 0` is ignored.
- **CLEAR**
  - Entered from any state when `abort_i = 1`. `abort_i` has priority over all other transitions.
  - One cycle with `arr_flush_o = 1` and `arr_yumi_o = arr_valid_i` (stale results are discarded).
  - Clears all counters, then goes to LOAD.
  - `abort_i` held high keeps the block in CLEAR.
- Outside the states listed above, `ready_o`, `arr_valid_o`, `arr_yumi_o`, `valid_o` and `arr_flush_o` are 0.
- Counters use `$clog2(num_ops_p+1)` bits and never wrap.
- Buffer contents are not reset; only the pointers are.

## Timing
- Reset values:
  - state LOAD; all counters 0.
  - `valid_o`, `arr_flush_o`, `arr_yumi_o`, `done_o`, `error_o` = 0.
  - `ready_o` follows `arr_ready_i`.
- LOAD operand path: 0-cycle latency, combinational.
- Last operand handshake at cycle t → `arr_flush_o` high at t+1 → COLLECT at t+2.
- Result handshake at cycle t → data visible on `data_o` no earlier than t+1, in DRAIN.
- Last COLLECT handshake at t → `valid_o = 1` at t+1.
- `done_o` is registered: high in the cycle after the final yumi, coinciding with LOAD.
- `reset_i` asserted mid-job returns to LOAD immediately. No flush is issued; the array shares the same reset.

## Configuration
- `MATMUL_SEQ_TIMEOUT_EN` defined:
  - A `timeout_width_p`-bit watchdog clears on entry to COLLECT and on every result handshake.
  - On reaching all-ones in COLLECT, it pulses `error_o` and enters CLEAR.
- Undefined:
  - No watchdog logic.
  - `error_o` is tied 0.
  - COLLECT waits indefinitely.

## Structure
- Package `matmul_seq_pkg`:
  - `typedef enum logic [2:0] state_e` with LOAD=0, FLUSH=1, COLLECT=2, DRAIN=3, CLEAR=4; `state_o` is driven with this encoding.
  - A `count_width` function for the counter sizing.
- One sub-module, `seq_result_buf`: a `num_macs_p` × `width_p` register file with write-enable/write-index and an asynchronous read-index. It has no reset.

## Test plan
- **Normal job.** Stream 8 operands with `arr_ready_i = 1`, then return results 0x11, 0x22, 0x33, 0x44. Required:
  - `arr_flush_o` high for exactly 1 cycle, one cycle after the 8th operand.
  - `data_o` sequence 0x11, 0x22, 0x33, 0x44 under `yumi_i = 1`.
  - `done_o` pulses once; state returns to LOAD.
- **Backpressure.** Hold `arr_ready_i = 0` for 5 cycles mid-load. Required: `ready_o = 0`, `op_cnt` holds, and no operand is lost or duplicated.
- **Slow consumer.** In DRAIN, pulse `yumi_i` every 3rd cycle. Required: `data_o` is stable between yumis, `arr_yumi_o = 0`, and a 5th result offered by the array is not accepted.
- **Abort mid-COLLECT.** Abort after 2 results. Required:
  - One CLEAR cycle with `arr_flush_o = 1`, then LOAD.
  - The next job's first `data_o` equals its own first result, not 0x11.
- **Async reset during DRAIN.** Required: `valid_o` drops without waiting for a clock edge; state_o = 0.
- **Watchdog** (with `MATMUL_SEQ_TIMEOUT_EN`, `timeout_width_p = 4`). Give no results after FLUSH. Required: `error_o` pulses 15 cycles after COLLECT entry, then CLEAR, then LOAD.
